// File: rtl/tia_hcount_pkg.sv
// Shared definitions for the TIA horizontal counter: LFSR step function and
// the decode patterns, derived from step indices so they stay consistent.
package tia_hcount_pkg;

    localparam int STEP_W = 6;

    localparam int END_STEP  = 56;
    localparam int SHS_STEP  = 4;
    localparam int RHS_STEP  = 8;
    localparam int RCB_STEP  = 12;
    localparam int RHB_STEP  = 16;
    localparam int LRHB_STEP = 18;
    localparam int CNT_STEP  = 36;

    typedef logic [STEP_W-1:0] lfsr_t;

    // XNOR feedback (x^6 + x^5 + 1); all-ones is the lockup state and never reached from zero
    function automatic lfsr_t lfsr_next(input lfsr_t s);
        return {s[STEP_W-2:0], ~(s[STEP_W-1] ^ s[STEP_W-2])};
    endfunction

    function automatic lfsr_t lfsr_at(input int n);
        lfsr_t s;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s = lfsr_next(s);
        end
        return s;
    endfunction

    localparam lfsr_t END_PAT  = lfsr_at(END_STEP);
    localparam lfsr_t SHS_PAT  = lfsr_at(SHS_STEP);
    localparam lfsr_t RHS_PAT  = lfsr_at(RHS_STEP);
    localparam lfsr_t RCB_PAT  = lfsr_at(RCB_STEP);
    localparam lfsr_t RHB_PAT  = lfsr_at(RHB_STEP);
    localparam lfsr_t LRHB_PAT = lfsr_at(LRHB_STEP);
    localparam lfsr_t CNT_PAT  = lfsr_at(CNT_STEP);

endpackage

// File: rtl/tia_phase_gen.sv
// Two-bit colour-clock phase counter producing the hphi1/hphi2 strobes and
// the step-boundary qualifier (high during phase 3, so the next edge starts a step).
module tia_phase_gen (
    input  logic clk,
    input  logic reset,
    output logic hphi1,
    output logic hphi2,
    output logic boundary
);

    logic [1:0] phase;

    // Strobes are registered on the edge that moves the phase to 0 and 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 2'd0;
            hphi1 <= 1'b0;
            hphi2 <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            hphi1 <= (phase == 2'd3);
            hphi2 <= (phase == 2'd1);
        end
    end

    assign boundary = (phase == 2'd3);

endmodule

// File: rtl/tia_hcount.sv
// TIA horizontal sync counter: 57-step LFSR, 4 colour clocks per step, with
// HSYNC/HBLANK/burst/centre/eol decode. Optional debug step index: TIA_HCOUNT_STEP_EN.
module tia_hcount
    import tia_hcount_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rsync,
    input  logic              hmove,
    output logic              hphi1,
    output logic              hphi2,
    output logic [STEP_W-1:0] hcount,
    output logic              hsync,
    output logic              hblank,
    output logic              burst,
    output logic              center,
    output logic              eol
`ifdef TIA_HCOUNT_STEP_EN
    ,
    output logic [STEP_W-1:0] step
`endif
);

    logic  boundary;
    logic  wrap;
    logic  rsync_pend;
    logic  hmove_latch;
    lfsr_t lfsr;
    lfsr_t lfsr_nxt;

    tia_phase_gen u_phase (
        .clk      (clk),
        .reset    (reset),
        .hphi1    (hphi1),
        .hphi2    (hphi2),
        .boundary (boundary)
    );

    // An rsync arriving on the boundary edge itself wraps immediately, so it never leaves a pending request
    assign wrap     = boundary && (rsync_pend || rsync || (lfsr == END_PAT));
    assign lfsr_nxt = wrap ? '0 : lfsr_next(lfsr);
    assign hcount   = lfsr;

    // Flags decode the next LFSR value so they move on the same edge as hcount
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr        <= '0;
            rsync_pend  <= 1'b0;
            hmove_latch <= 1'b0;
            hsync       <= 1'b0;
            hblank      <= 1'b1;
            burst       <= 1'b0;
            center      <= 1'b0;
            eol         <= 1'b0;
        end else begin
            center <= 1'b0;
            eol    <= 1'b0;

            if (boundary) begin
                rsync_pend <= 1'b0;
            end else if (rsync) begin
                rsync_pend <= 1'b1;
            end

            if (hmove) begin
                hmove_latch <= 1'b1;
            end else if (wrap) begin
                hmove_latch <= 1'b0;
            end

            if (boundary) begin
                lfsr   <= lfsr_nxt;
                eol    <= wrap;
                center <= (lfsr_nxt == CNT_PAT);

                if (wrap) begin
                    hblank <= 1'b1;
                end else if ((lfsr_nxt == RHB_PAT) && !hmove_latch) begin
                    hblank <= 1'b0;
                end else if (lfsr_nxt == LRHB_PAT) begin
                    hblank <= 1'b0;
                end

                if (lfsr_nxt == SHS_PAT) begin
                    hsync <= 1'b1;
                end else if (lfsr_nxt == RHS_PAT) begin
                    hsync <= 1'b0;
                end

                if (lfsr_nxt == RHS_PAT) begin
                    burst <= 1'b1;
                end else if (lfsr_nxt == RCB_PAT) begin
                    burst <= 1'b0;
                end
            end
        end
    end

`ifdef TIA_HCOUNT_STEP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step <= '0;
        end else if (boundary) begin
            step <= wrap ? '0 : step + 6'd1;
        end
    end
`endif

endmodule
